// File: rtl/pipe_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_cla_adder
//  Description : Pipelined adder/subtractor. Each stage adds one SEG_W-bit
//                segment with 4-bit carry-lookahead groups. Group carries
//                ripple within the segment. The segment carry is registered
//                into the next stage. Operand segments that are not yet
//                added, and result segments already produced, travel
//                skewed through the pipe so that each slot holds one
//                complete transaction.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters  : WIDTH  operand/result width (multiple of SEG_W)
//                SEG_W  bits per stage (multiple of 4)
//  Ports       : clk, rst (synchronous, active-high)
//                in_valid/in_ready  input handshake; a, b, cin, sub operands
//                out_valid/out_ready output handshake; sum, cout, ovf result
//  Option      : define PIPE_CLA_OVF_EN to enable the signed overflow flag;
//                otherwise ovf is tied to 0.
// ============================================================================
module pipe_cla_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES   = WIDTH / SEG_W;
    localparam int c_groups = SEG_W / 4;

    // One segment: 4-bit lookahead groups, with the group carry rippling.
    function automatic logic [SEG_W:0] cla_seg(
        input logic [SEG_W-1:0] x,
        input logic [SEG_W-1:0] y,
        input logic             ci
    );
        logic [SEG_W-1:0] s;
        logic [3:0]       p;
        logic [3:0]       g;
        logic [4:0]       c;
        logic             cr;
        s  = '0;
        cr = ci;
        for (int i = 0; i < c_groups; i++) begin
            p    = x[i*4 +: 4] ^ y[i*4 +: 4];
            g    = x[i*4 +: 4] & y[i*4 +: 4];
            c[0] = cr;
            c[1] = g[0] | (p[0] & cr);
            c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cr);
            c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                 | (p[2] & p[1] & p[0] & cr);
            c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                 | (p[3] & p[2] & p[1] & g[0]) | (&p & cr);
            s[i*4 +: 4] = p ^ c[3:0];
            cr = c[4];
        end
        return {cr, s};
    endfunction

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;

    // Next-state values of every slot, produced by the stage adders.
    logic             w_v_nxt [STAGES];
    logic [WIDTH-1:0] w_x_nxt [STAGES];
    logic [WIDTH-1:0] w_b_nxt [STAGES];
    logic             w_c_nxt [STAGES];

    // Slot registers. r_x holds the finished sum segments in its low bits
    // and the remaining operand-A segments in its high bits.
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_x   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic             r_cy  [STAGES];

`ifdef PIPE_CLA_OVF_EN
    logic w_ovf_nxt;
    logic r_ovf;
`endif

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // Subtraction is folded in at the entry: a + ~b + 1, with cin ignored.
    assign w_b_eff = sub ? ~b : b;
    assign w_c0    = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] w_x_in;
        logic [WIDTH-1:0] w_b_in;
        logic             w_c_in;
        logic             w_v_in;
        logic [SEG_W:0]   w_seg;
        logic [WIDTH-1:0] w_x_mrg;

        if (k == 0) begin : g_head
            assign w_x_in = a;
            assign w_b_in = w_b_eff;
            assign w_c_in = w_c0;
            assign w_v_in = in_valid;
        end else begin : g_body
            assign w_x_in = r_x[k-1];
            assign w_b_in = r_b[k-1];
            assign w_c_in = r_cy[k-1];
            assign w_v_in = r_vld[k-1];
        end

        assign w_seg = cla_seg(w_x_in[k*SEG_W +: SEG_W], w_b_in[k*SEG_W +: SEG_W], w_c_in);

        // Overwrite the consumed A segment with its sum segment.
        always_comb begin
            w_x_mrg = w_x_in;
            w_x_mrg[k*SEG_W +: SEG_W] = w_seg[SEG_W-1:0];
        end

        assign w_v_nxt[k] = w_v_in;
        assign w_x_nxt[k] = w_x_mrg;
        assign w_b_nxt[k] = w_b_in;
        assign w_c_nxt[k] = w_seg[SEG_W];

`ifdef PIPE_CLA_OVF_EN
        // The top A bit is still untouched in w_x_in at the last stage.
        if (k == STAGES - 1) begin : g_ovf
            assign w_ovf_nxt = (w_x_in[WIDTH-1] == w_b_in[WIDTH-1])
                            && (w_seg[SEG_W-1] != w_x_in[WIDTH-1]);
        end
`endif
    end

    // The whole pipe shifts together. Data registers load only for real
    // transactions, so a bubble leaves the previous contents in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_x[k]   <= '0;
                r_cy[k]  <= 1'b0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= w_v_nxt[k];
                if (w_v_nxt[k]) begin
                    r_x[k]  <= w_x_nxt[k];
                    r_cy[k] <= w_c_nxt[k];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_v_nxt[k]) begin
                    r_b[k] <= w_b_nxt[k];
                end
            end
        end
    end

`ifdef PIPE_CLA_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_advance && w_v_nxt[STAGES-1]) begin
            r_ovf <= w_ovf_nxt;
        end
    end
    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign out_valid = r_vld[STAGES-1];
    assign sum       = r_x[STAGES-1];
    assign cout      = r_cy[STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_pipe_cla_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_cla_adder
//  Description : Scoreboard bench for pipe_cla_adder (WIDTH=32, SEG_W=8).
//                The bench pushes the expected results when a transfer is
//                accepted. A monitor collects the DUT outputs, and each
//                scenario task compares the two queues in order.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_cla_adder;

    localparam int WIDTH  = 32;
    localparam int SEG_W  = 8;
    localparam int STAGES = WIDTH / SEG_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               cyc;
    } res_t;

    res_t exp_q[$];
    res_t got_q[$];
    res_t mon_r;

    pipe_cla_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            mon_r.sum  = sum;
            mon_r.cout = cout;
            mon_r.ovf  = ovf;
            mon_r.cyc  = cyc;
            got_q.push_back(mon_r);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    function automatic res_t model(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                                   input logic tcin, input logic tsub, input int tc);
        res_t           r;
        logic [WIDTH:0] full;
        logic [WIDTH-1:0] be;
        be   = tsub ? ~tb_ : tb_;
        full = {1'b0, ta} + {1'b0, be} + (tsub ? 33'd1 : {32'd0, tcin});
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
`ifdef PIPE_CLA_OVF_EN
        r.ovf  = (ta[WIDTH-1] == be[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);
`else
        r.ovf  = 1'b0;
`endif
        r.cyc  = tc;
        return r;
    endfunction

    // One cycle of stimulus, starting just after a rising edge.
    task automatic drive(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tcin, input logic tsub, input logic tv);
        a        = ta;
        b        = tb_;
        cin      = tcin;
        sub      = tsub;
        in_valid = tv;
        #1;
        if (tv && in_ready === 1'b1 && rst === 1'b0)
            exp_q.push_back(model(ta, tb_, tcin, tsub, cyc));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        a         = 32'h1234_5678;
        b         = 32'h1111_1111;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({out_valid, sum, cout, ovf} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got v=%b s=%h c=%b o=%b want 0/0/0/0", out_valid, sum, cout, ovf);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_in_ready: got=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL reset_no_accept: got=%0d outputs want=0", got_q.size());
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_carry_wrap();
        res_t g;
        res_t e;
        out_ready = 1'b1;
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got_q.size() != 1 || exp_q.size() != 1) begin
            bad++;
            $display("FAIL wrap_count: got=%0d want=1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if ({g.sum, g.cout, g.ovf} !== {32'h0, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL wrap_value: got=%h/%b/%b want=00000000/1/0", g.sum, g.cout, g.ovf);
            end
            total++;
            if (g.cyc - e.cyc != STAGES) begin
                bad++;
                $display("FAIL wrap_latency: got=%0d want=%0d", g.cyc - e.cyc, STAGES);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_overflow();
        res_t g;
        logic want_ovf;
`ifdef PIPE_CLA_OVF_EN
        want_ovf = 1'b1;
`else
        want_ovf = 1'b0;
`endif
        out_ready = 1'b1;
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got_q.size() != 1) begin
            bad++;
            $display("FAIL ovf_count: got=%0d want=1", got_q.size());
        end else begin
            g = got_q.pop_front();
            total++;
            if ({g.sum, g.cout, g.ovf} !== {32'h8000_0000, 1'b0, want_ovf}) begin
                bad++;
                $display("FAIL ovf_value: got=%h/%b/%b want=80000000/0/%b", g.sum, g.cout, g.ovf, want_ovf);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_subtract();
        res_t g;
        out_ready = 1'b1;
        drive(32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
        drive(32'd9, 32'd4, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got_q.size() != 2) begin
            bad++;
            $display("FAIL sub_count: got=%0d want=2", got_q.size());
        end else begin
            g = got_q.pop_front();
            total++;
            if ({g.sum, g.cout} !== {32'hFFFF_FFFE, 1'b0}) begin
                bad++;
                $display("FAIL sub_borrow: got=%h/%b want=fffffffe/0", g.sum, g.cout);
            end
            g = got_q.pop_front();
            total++;
            if ({g.sum, g.cout} !== {32'h0000_0005, 1'b1}) begin
                bad++;
                $display("FAIL sub_noborrow: got=%h/%b want=00000005/1", g.sum, g.cout);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        res_t g;
        res_t e;
        int   first;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive(32'(i), 32'(i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got_q.size() != 8 || exp_q.size() != 8) begin
            bad++;
            $display("FAIL b2b_count: got=%0d want=8", got_q.size());
        end else begin
            first = got_q[0].cyc;
            for (int i = 0; i < 8; i++) begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                total++;
                if (g.sum !== 32'(2 * i) || g.cout !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_sum[%0d]: got=%h/%b want=%h/0", i, g.sum, g.cout, 32'(2 * i));
                end
                total++;
                if (g.cyc - e.cyc != STAGES || g.cyc != first + i) begin
                    bad++;
                    $display("FAIL b2b_timing[%0d]: got lat=%0d slot=%0d want lat=%0d slot=%0d",
                             i, g.cyc - e.cyc, g.cyc - first, STAGES, i);
                end
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_backpressure();
        res_t g;
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) drive(32'h1000_0000 * i + 32'h11, 32'h0100_0003 * i, 1'b1, 1'b0, 1'b1);
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            a        = 32'hDEAD_BEEF;
            b        = 32'h1;
            in_valid = 1'b1;
            #1;
            total++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== exp_q[0].sum || cout !== exp_q[0].cout) begin
                bad++;
                $display("FAIL stall_hold[%0d]: got rdy=%b v=%b s=%h c=%b want rdy=0 v=1 s=%h c=%b",
                         s, in_ready, out_valid, sum, cout, exp_q[0].sum, exp_q[0].cout);
            end
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        drive(32'hDEAD_BEEF, 32'h1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got_q.size() != 5 || exp_q.size() != 5) begin
            bad++;
            $display("FAIL drain_count: got=%0d want=5", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if ({g.sum, g.cout, g.ovf} !== {e.sum, e.cout, e.ovf}) begin
                bad++;
                $display("FAIL drain_order: got=%h/%b/%b want=%h/%b/%b", g.sum, g.cout, g.ovf, e.sum, e.cout, e.ovf);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_in_flight();
        res_t g;
        res_t e;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) drive(32'hA5A5_0000 + 32'(i), 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b1);
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 32'h7777_7777;
        @(posedge clk);
        #1;
        total++;
        if ({out_valid, sum, cout} !== {1'b0, 32'h0, 1'b0}) begin
            bad++;
            $display("FAIL flush_state: got v=%b s=%h c=%b want 0/00000000/0", out_valid, sum, cout);
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_in_ready: got=%b want=1", in_ready);
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got_q.size() != 0) begin
            bad++;
            $display("FAIL flush_stale: got=%0d outputs want=0", got_q.size());
        end
        got_q.delete();
        drive(32'h0000_1234, 32'h0000_4321, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 20 && got_q.size() < exp_q.size(); i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got_q.size() != 1) begin
            bad++;
            $display("FAIL flush_restart_count: got=%0d want=1", got_q.size());
        end else begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if (g.sum !== 32'h0000_5556 || g.cyc - e.cyc != STAGES) begin
                bad++;
                $display("FAIL flush_restart: got=%h lat=%0d want=00005556 lat=%0d", g.sum, g.cyc - e.cyc, STAGES);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        res_t g;
        res_t e;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        for (int i = 0; i < 60; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            ra = $urandom();
            rb = $urandom();
            if (i % 7 == 0) ra = 32'hFFFF_FFFF;
            if (i % 11 == 0) rb = 32'h8000_0000;
            drive(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 4) != 0));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 40 && got_q.size() < exp_q.size(); i++) drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (got_q.size() != exp_q.size()) begin
            bad++;
            $display("FAIL rand_count: got=%0d want=%0d", got_q.size(), exp_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            total++;
            if ({g.sum, g.cout, g.ovf} !== {e.sum, e.cout, e.ovf}) begin
                bad++;
                $display("FAIL rand_result: got=%h/%b/%b want=%h/%b/%b", g.sum, g.cout, g.ovf, e.sum, e.cout, e.ovf);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_backpressure();
        test_reset_in_flight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
